// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory slave with RISC-V load/store
// sizing, configurable wait states and a valid/ready response channel.
// Storage is a 2**(DM_ADDRESS-2) x DATA_W word array with little-endian byte lanes.
// The request is registered on accept. A WAIT phase then counts out the wait
// states. Memory is touched only on the edge that raises rsp_valid.

module dmem_responder #(
  parameter int DM_ADDRESS  = 9,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err
);

  localparam int         WORDS     = 2 ** (DM_ADDRESS - 2);
  localparam int         LANES     = DATA_W / 8;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t                  state;
  logic [3:0]              wait_cnt;
  logic                    acc_write;
  logic [DM_ADDRESS-1:0]   acc_addr;
  logic [DATA_W-1:0]       acc_wdata;
  logic [2:0]              acc_funct3;
  logic                    acc_err;

  logic [DATA_W-1:0]       mem [WORDS];

  logic                    req_illegal;
  logic                    req_misaligned;
  logic                    req_err;
  logic [DM_ADDRESS-3:0]   word_idx;
  logic [DATA_W-1:0]       rd_word;
  logic [DATA_W-1:0]       byte_shift;
  logic [DATA_W-1:0]       half_shift;
  logic [DATA_W-1:0]       load_data;
  logic [LANES-1:0]        byte_en;
  logic [DATA_W-1:0]       wr_data;
  logic                    commit;
  logic                    store_commit;

  // Classify the presented request as illegal or misaligned before accepting it
  always_comb begin
    req_illegal    = 1'b0;
    req_misaligned = 1'b0;
    if (req_write) begin
      req_illegal = (req_funct3 > 3'd2);
    end else begin
      req_illegal = !(req_funct3 == 3'd0 || req_funct3 == 3'd1 || req_funct3 == 3'd2 ||
                      req_funct3 == 3'd4 || req_funct3 == 3'd5);
    end
    if (req_funct3[1:0] == 2'd1) begin
      req_misaligned = req_addr[0];
    end else if (req_funct3[1:0] == 2'd2) begin
      req_misaligned = (req_addr[1:0] != 2'b00);
    end
    req_err = req_illegal || req_misaligned;
  end

  // Extract and extend the addressed byte or halfword of the latched word for loads
  always_comb begin
    word_idx   = acc_addr[DM_ADDRESS-1:2];
    rd_word    = mem[word_idx];
    byte_shift = rd_word >> {acc_addr[1:0], 3'b000};
    half_shift = rd_word >> {acc_addr[1], 4'b0000};
    load_data  = '0;
    case (acc_funct3)
      3'd0:    load_data = {{(DATA_W-8){byte_shift[7]}}, byte_shift[7:0]};
      3'd1:    load_data = {{(DATA_W-16){half_shift[15]}}, half_shift[15:0]};
      3'd2:    load_data = rd_word;
      3'd4:    load_data = {{(DATA_W-8){1'b0}}, byte_shift[7:0]};
      3'd5:    load_data = {{(DATA_W-16){1'b0}}, half_shift[15:0]};
      default: load_data = '0;
    endcase
  end

  // Build store byte enables and lane-replicated write data from the latched request
  always_comb begin
    byte_en = '0;
    wr_data = acc_wdata;
    case (acc_funct3)
      3'd0: begin
        byte_en = LANES'(1) << acc_addr[1:0];
        wr_data = {LANES{acc_wdata[7:0]}};
      end
      3'd1: begin
        byte_en = LANES'(3) << {acc_addr[1], 1'b0};
        wr_data = {(LANES/2){acc_wdata[15:0]}};
      end
      3'd2: begin
        byte_en = '1;
        wr_data = acc_wdata;
      end
      default: begin
        byte_en = '0;
        wr_data = acc_wdata;
      end
    endcase
    commit       = (state == WAIT) && (wait_cnt == 4'd0);
    store_commit = commit && acc_write && !acc_err;
  end

  // Commit store lanes on the edge that raises the response; reset aborts and never clears
  always_ff @(posedge clk) begin
    if (!reset && store_commit) begin
      for (int b = 0; b < LANES; b++) begin
        if (byte_en[b]) begin
          mem[word_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  // Control FSM: accept and latch, count wait states, then present and hold the response
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= 4'd0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      acc_write  <= 1'b0;
      acc_addr   <= '0;
      acc_wdata  <= '0;
      acc_funct3 <= 3'd0;
      acc_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            acc_write  <= req_write;
            acc_addr   <= req_addr;
            acc_wdata  <= req_wdata;
            acc_funct3 <= req_funct3;
            acc_err    <= req_err;
            wait_cnt   <= req_err ? 4'd0 : WAIT_LOAD;
            req_ready  <= 1'b0;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= acc_err;
            rsp_rdata <= (acc_err || acc_write) ? '0 : load_data;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b0;
          rsp_valid <= 1'b0;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DM_ADDRESS, default 9, SHALL set the byte-address width (512-byte space).
REQ-002 Parameter DATA_W, default 32, SHALL set the data width.
REQ-003 Parameter WAIT_CYCLES, default 2, range 0..15, SHALL set the wait states inserted per accepted access.
REQ-004 Port clk, input, 1, SHALL be the clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1, SHALL be a synchronous, active-high reset.
REQ-006 Port req_valid, input, 1, SHALL indicate that the initiator presents an access.
REQ-007 Port req_ready, output, 1, SHALL indicate that the block accepts the access this cycle.
REQ-008 Port req_write, input, 1, SHALL select store (1) or load (0).
REQ-009 Port req_addr, input, DM_ADDRESS, SHALL carry the byte address.
REQ-010 Port req_wdata, input, DATA_W, SHALL carry store data, LSB-aligned.
REQ-011 Port req_funct3, input, 3, SHALL carry the RISC-V funct3 access size/sign code.
REQ-012 Port rsp_valid, output, 1, SHALL indicate a valid response.
REQ-013 Port rsp_ready, input, 1, SHALL indicate that the initiator takes the response.
REQ-014 Port rsp_rdata, output, DATA_W, SHALL carry extended load data; 0 for stores and errors.
REQ-015 Port rsp_err, output, 1, SHALL flag a misaligned or illegal access.

Function
REQ-016 Storage SHALL be 128 x 32-bit words, indexed by req_addr[8:2], little-endian byte lanes.
REQ-017 FSM SHALL have states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-018 Accept = req_valid & req_ready; on accept, write, addr, wdata and funct3 SHALL be registered, and later input changes SHALL be ignored.
REQ-019 Legal loads: funct3 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; legal stores: 0 SB, 1 SH, 2 SW; any other code SHALL be illegal.
REQ-020 Misaligned: halfword with addr[0]=1, word with addr[1:0]!=0.
REQ-021 Illegal or misaligned access: IDLE->RESP next cycle, rsp_err=1, rsp_rdata=0, memory unchanged.
REQ-022 Legal access: IDLE->WAIT, or IDLE->RESP directly if WAIT_CYCLES=0; a counter SHALL count WAIT_CYCLES cycles in WAIT, then go to RESP.
REQ-023 Latency: accept at edge N -> rsp_valid high after edge N+1+WAIT_CYCLES.
REQ-024 A store SHALL commit only its addressed lanes (SB: 1 lane, SH: lanes addr[1]*2..+1, SW: all 4) on the edge that enters RESP.
REQ-025 Load data SHALL be sampled on the edge entering RESP; LB/LH sign-extend, LBU/LHU zero-extend, with the selected byte/half moved to bit 0.
REQ-026 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until rsp_ready=1; on rsp_valid & rsp_ready the FSM SHALL return to IDLE.
REQ-027 Throughput: at most one access in flight; the next accept is possible the cycle after the response handshake.
REQ-028 Outside RESP, rsp_valid=0, rsp_rdata=0 and rsp_err=0.

Reset
REQ-029 While reset=1: state IDLE, counter 0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0; req_ready=1 from the first cycle after deassertion.
REQ-030 Reset before the commit edge SHALL abort the access with no memory write; the memory array SHALL NOT be cleared by reset (initial contents 0).

Verification
REQ-031 SW 0xDEADBEEF @0x010, then LW @0x010, WAIT_CYCLES=2 -> each rsp_valid 3 cycles after accept; load returns 0xDEADBEEF, err=0.
REQ-032 SB 0x80 @0x013 over 0x00000000, then LB @0x013 -> 0xFFFFFF80; LBU @0x013 -> 0x00000080; LW @0x010 -> 0x80000000.
REQ-033 SH 0x1234 @0x022, then LHU @0x022 -> 0x00001234; LH @0x021 -> err=1, rdata=0, response 1 cycle after accept.
REQ-034 SW @0x031 and funct3=3 store -> err=1, word 0x030 unchanged on subsequent LW.
REQ-035 rsp_ready held 0 for 5 cycles -> rsp_valid/rdata stable, req_ready=0 throughout; handshake -> accept possible next cycle.
REQ-036 Reset pulsed in WAIT of SW 0x55 @0x040 -> rsp_valid=0, later LW @0x040 returns the prior value.
